// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-RAM arbiter and its CPU, DMA, RAM and I/O neighbours.
// The arbiter uses the slave view; the requesters and RAM together form the master view.
interface dmem_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          dma_req;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  logic          ram_cs;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          stdout_valid;
  logic [DW-1:0] stdout_data;
  logic          halt;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_cs, ram_wr, ram_addr, ram_wdata,
    input  ram_rdata,
    output stdout_valid, stdout_data, halt
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_cs, ram_wr, ram_addr, ram_wdata,
    output ram_rdata,
    input  stdout_valid, stdout_data, halt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU priority with a forced DMA slot after MAX_WAIT
// denials, plus decode of the CPU stdout (0xFFFFFE) and halt (0xFFFFFF) words.
module dmem_arbiter #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam logic [3:0]    WAIT_LIM    = 4'(MAX_WAIT);
  localparam logic [AW-1:0] ADDR_STDOUT = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [AW-1:0] ADDR_HALT   = {AW{1'b1}};

  owner_t        owner;
  logic          cpu_own;
  logic          dma_own;
  logic          cpu_live;
  logic          dma_live;
  logic          cpu_io;
  logic          dma_io;
  logic [3:0]    wait_cnt;
  logic          halt_q;
  logic          stdout_valid_q;
  logic [DW-1:0] stdout_data_q;

  logic          rd_cpu_q;
  logic          rd_cpu_io_q;
  logic          rd_dma_q;
  logic          rd_dma_io_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic [DW-1:0] cpu_ret;
  logic [DW-1:0] dma_ret;

  assign cpu_io = (bus.cpu_addr >= ADDR_STDOUT);
  assign dma_io = (bus.dma_addr >= ADDR_STDOUT);

  // Reset and halt gate requests here so the owner decode never serves them.
  assign cpu_live = bus.cpu_req & ~halt_q & ~i_rst;
  assign dma_live = bus.dma_req & ~i_rst;

  always_comb begin
    owner = OWN_NONE;
    if (cpu_live && dma_live) begin
      owner = (wait_cnt == WAIT_LIM) ? OWN_DMA : OWN_CPU;
    end else if (cpu_live) begin
      owner = OWN_CPU;
    end else if (dma_live) begin
      owner = OWN_DMA;
    end
  end

  assign cpu_own = (owner == OWN_CPU);
  assign dma_own = (owner == OWN_DMA);

  always_comb begin
    bus.cpu_stall = bus.cpu_req & ~cpu_own;
    bus.dma_gnt   = dma_own;
    bus.ram_cs    = (cpu_own & ~cpu_io) | (dma_own & ~dma_io);
    bus.ram_wr    = bus.ram_cs & (dma_own ? bus.dma_wr : bus.cpu_wr);
    bus.ram_addr  = dma_own ? bus.dma_addr  : bus.cpu_addr;
    bus.ram_wdata = dma_own ? bus.dma_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= 4'd0;
    end else if (!bus.dma_req || dma_own) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt_q         <= 1'b0;
      stdout_valid_q <= 1'b0;
      stdout_data_q  <= '0;
    end else begin
      stdout_valid_q <= 1'b0;
      if (cpu_own && bus.cpu_wr && bus.cpu_addr == ADDR_STDOUT) begin
        stdout_valid_q <= 1'b1;
        stdout_data_q  <= bus.cpu_wdata;
      end
      if (cpu_own && bus.cpu_wr && bus.cpu_addr == ADDR_HALT) begin
        halt_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_cpu_q    <= 1'b0;
      rd_cpu_io_q <= 1'b0;
      rd_dma_q    <= 1'b0;
      rd_dma_io_q <= 1'b0;
    end else begin
      rd_cpu_q    <= cpu_own & ~bus.cpu_wr;
      rd_cpu_io_q <= cpu_io;
      rd_dma_q    <= dma_own & ~bus.dma_wr;
      rd_dma_io_q <= dma_io;
    end
  end

  // The RAM answers one cycle after the grant, so returned data is muxed live
  // and captured into the hold registers for the following cycles.
  assign cpu_ret = rd_cpu_io_q ? '0 : bus.ram_rdata;
  assign dma_ret = rd_dma_io_q ? '0 : bus.ram_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (rd_cpu_q) cpu_rdata_q <= cpu_ret;
      if (rd_dma_q) dma_rdata_q <= dma_ret;
    end
  end

  always_comb begin
    bus.cpu_rvalid   = rd_cpu_q;
    bus.cpu_rdata    = rd_cpu_q ? cpu_ret : cpu_rdata_q;
    bus.dma_rvalid   = rd_dma_q;
    bus.dma_rdata    = rd_dma_q ? dma_ret : dma_rdata_q;
    bus.stdout_valid = stdout_valid_q;
    bus.stdout_data  = stdout_data_q;
    bus.halt         = halt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous RAM model behind it.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  dmem_arbiter_if #(.AW(24), .DW(32)) bus ();

  dmem_arbiter #(.AW(24), .DW(32), .MAX_WAIT(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic [31:0] ram_q;

  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_wr) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
      ram_q <= mem[bus.ram_addr[7:0]];
    end
  end
  assign bus.ram_rdata = ram_q;

  task automatic drive_cpu(input logic req, input logic wr, input logic [23:0] addr,
                           input logic [31:0] wdata);
    bus.cpu_req = req; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic drive_dma(input logic req, input logic wr, input logic [23:0] addr,
                           input logic [31:0] wdata);
    bus.dma_req = req; bus.dma_wr = wr; bus.dma_addr = addr; bus.dma_wdata = wdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_cpu(1'b1, 1'b0, 24'h000010, 32'h0);
    drive_dma(1'b1, 1'b0, 24'h000020, 32'h0);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall got=%0b exp=1", bus.cpu_stall); end
    n_cmp++; if (bus.ram_cs !== 1'b0) begin n_err++; $display("FAIL rst_cs got=%0b exp=0", bus.ram_cs); end
    n_cmp++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt got=%0b exp=0", bus.dma_gnt); end
    n_cmp++; if (bus.halt !== 1'b0) begin n_err++; $display("FAIL rst_halt got=%0b exp=0", bus.halt); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%0b%0b exp=00", bus.cpu_rvalid, bus.dma_rvalid); end
    n_cmp++; if (bus.stdout_valid !== 1'b0 || bus.stdout_data !== 32'h0) begin n_err++; $display("FAIL rst_stdout got=%0b/%h exp=0/0", bus.stdout_valid, bus.stdout_data); end
    n_cmp++; if (bus.cpu_rdata !== 32'h0 || bus.dma_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h/%h exp=0/0", bus.cpu_rdata, bus.dma_rdata); end
    drive_cpu(1'b0, 1'b0, 24'h0, 32'h0);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_idle got=%0b exp=0", bus.cpu_stall); end
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cpu_rw;
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 24'h000010, 32'hDEADBEEF);
    #1;
    n_cmp++; if (bus.ram_cs !== 1'b1 || bus.ram_wr !== 1'b1) begin n_err++; $display("FAIL cpuw_cs got=%0b%0b exp=11", bus.ram_cs, bus.ram_wr); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpuw_stall got=%0b exp=0", bus.cpu_stall); end
    n_cmp++; if (bus.ram_addr !== 24'h000010 || bus.ram_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpuw_bus got=%h/%h exp=000010/deadbeef", bus.ram_addr, bus.ram_wdata); end
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 24'h000010, 32'h0);
    #1;
    n_cmp++; if (bus.ram_cs !== 1'b1 || bus.ram_wr !== 1'b0) begin n_err++; $display("FAIL cpur_cs got=%0b%0b exp=10", bus.ram_cs, bus.ram_wr); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL cpuw_norvalid got=%0b exp=0", bus.cpu_rvalid); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 24'h0, 32'h0);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpur_data got=%0b/%h exp=1/deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
    @(negedge clk);
    n_cmp++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpur_hold got=%0b/%h exp=0/deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_dma_only;
    @(negedge clk);
    drive_dma(1'b1, 1'b1, 24'h000020, 32'hCAFEF00D);
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.ram_cs !== 1'b1 || bus.ram_wr !== 1'b1) begin n_err++; $display("FAIL dmaw got=%0b%0b%0b exp=111", bus.dma_gnt, bus.ram_cs, bus.ram_wr); end
    n_cmp++; if (bus.ram_addr !== 24'h000020) begin n_err++; $display("FAIL dmaw_addr got=%h exp=000020", bus.ram_addr); end
    @(negedge clk);
    drive_dma(1'b1, 1'b0, 24'h000020, 32'h0);
    @(negedge clk);
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
    n_cmp++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL dmar_data got=%0b/%h exp=1/cafef00d", bus.dma_rvalid, bus.dma_rdata); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL dmar_cpurv got=%0b exp=0", bus.cpu_rvalid); end
  endtask

  task automatic test_forced_slot;
    logic prev_dma;
    logic exp_gnt;
    prev_dma = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) begin
        drive_cpu(1'b1, 1'b0, 24'h000010, 32'h0);
        drive_dma(1'b1, 1'b0, 24'h000020, 32'h0);
      end else begin
        n_cmp++; if (bus.dma_rvalid !== prev_dma || bus.cpu_rvalid !== !prev_dma) begin n_err++; $display("FAIL force_rv k=%0d got=%0b%0b exp=%0b%0b", k, bus.cpu_rvalid, bus.dma_rvalid, !prev_dma, prev_dma); end
        n_cmp++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL force_cpud k=%0d got=%h exp=deadbeef", k, bus.cpu_rdata); end
      end
      exp_gnt = (k % 5 == 0);
      #1;
      n_cmp++; if (bus.dma_gnt !== exp_gnt || bus.cpu_stall !== exp_gnt) begin n_err++; $display("FAIL force_gnt k=%0d got=%0b%0b exp=%0b%0b", k, bus.dma_gnt, bus.cpu_stall, exp_gnt, exp_gnt); end
      n_cmp++; if (bus.ram_addr !== (exp_gnt ? 24'h000020 : 24'h000010) || bus.ram_cs !== 1'b1) begin n_err++; $display("FAIL force_addr k=%0d got=%h cs=%0b", k, bus.ram_addr, bus.ram_cs); end
      prev_dma = exp_gnt;
    end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 24'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
    n_cmp++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL force_last got=%0b/%h exp=1/cafef00d", bus.dma_rvalid, bus.dma_rdata); end
  endtask

  task automatic test_stdout;
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 24'hFFFFFE, 32'h00000041);
    #1;
    n_cmp++; if (bus.ram_cs !== 1'b0 || bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL stdout_cs got=%0b stall=%0b exp=0/0", bus.ram_cs, bus.cpu_stall); end
    n_cmp++; if (bus.stdout_valid !== 1'b0) begin n_err++; $display("FAIL stdout_early got=%0b exp=0", bus.stdout_valid); end
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 24'hFFFFFE, 32'h0);
    n_cmp++; if (bus.stdout_valid !== 1'b1 || bus.stdout_data !== 32'h00000041) begin n_err++; $display("FAIL stdout_pulse got=%0b/%h exp=1/00000041", bus.stdout_valid, bus.stdout_data); end
    #1;
    n_cmp++; if (bus.ram_cs !== 1'b0) begin n_err++; $display("FAIL ioread_cs got=%0b exp=0", bus.ram_cs); end
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 24'h0, 32'h0);
    n_cmp++; if (bus.stdout_valid !== 1'b0 || bus.stdout_data !== 32'h00000041) begin n_err++; $display("FAIL stdout_hold got=%0b/%h exp=0/00000041", bus.stdout_valid, bus.stdout_data); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL ioread_data got=%0b/%h exp=1/0", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_dma_io;
    @(negedge clk);
    drive_dma(1'b1, 1'b0, 24'hFFFFFE, 32'h0);
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.ram_cs !== 1'b0) begin n_err++; $display("FAIL dmaio_gnt got=%0b cs=%0b exp=1/0", bus.dma_gnt, bus.ram_cs); end
    @(negedge clk);
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
    n_cmp++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'h0) begin n_err++; $display("FAIL dmaio_data got=%0b/%h exp=1/0", bus.dma_rvalid, bus.dma_rdata); end
    n_cmp++; if (bus.stdout_valid !== 1'b0) begin n_err++; $display("FAIL dmaio_stdout got=%0b exp=0", bus.stdout_valid); end
  endtask

  task automatic test_halt;
    @(negedge clk);
    drive_cpu(1'b1, 1'b1, 24'hFFFFFF, 32'h1);
    #1;
    n_cmp++; if (bus.ram_cs !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.halt !== 1'b0) begin n_err++; $display("FAIL haltw got=cs%0b st%0b h%0b exp=000", bus.ram_cs, bus.cpu_stall, bus.halt); end
    @(negedge clk);
    n_cmp++; if (bus.halt !== 1'b1) begin n_err++; $display("FAIL halt_set got=%0b exp=1", bus.halt); end
    drive_cpu(1'b1, 1'b0, 24'h000010, 32'h0);
    #1;
    n_cmp++; if (bus.cpu_stall !== 1'b1 || bus.ram_cs !== 1'b0) begin n_err++; $display("FAIL halt_stall got=%0b cs=%0b exp=1/0", bus.cpu_stall, bus.ram_cs); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.cpu_stall !== 1'b1 || bus.halt !== 1'b1 || bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL halt_sticky k=%0d got=st%0b h%0b rv%0b", k, bus.cpu_stall, bus.halt, bus.cpu_rvalid); end
    end
    @(negedge clk);
    drive_dma(1'b1, 1'b0, 24'h000010, 32'h0);
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.ram_cs !== 1'b1 || bus.ram_addr !== 24'h000010 || bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL halt_dma got=g%0b cs%0b a%h st%0b", bus.dma_gnt, bus.ram_cs, bus.ram_addr, bus.cpu_stall); end
    @(negedge clk);
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
    n_cmp++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 32'hDEADBEEF || bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL halt_dmard got=%0b/%h cpurv=%0b exp=1/deadbeef/0", bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    drive_dma(1'b1, 1'b0, 24'h000010, 32'h0);
    @(posedge clk);
    #2;
    n_cmp++; if (bus.dma_rvalid !== 1'b1) begin n_err++; $display("FAIL mid_pending got=%0b exp=1", bus.dma_rvalid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0) begin n_err++; $display("FAIL mid_discard got=%0b/%h exp=0/0", bus.dma_rvalid, bus.dma_rdata); end
    n_cmp++; if (bus.halt !== 1'b0 || bus.stdout_data !== 32'h0) begin n_err++; $display("FAIL mid_clear got=h%0b/%h exp=0/0", bus.halt, bus.stdout_data); end
    n_cmp++; if (bus.dma_gnt !== 1'b0 || bus.ram_cs !== 1'b0 || bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL mid_gate got=g%0b cs%0b st%0b exp=001", bus.dma_gnt, bus.ram_cs, bus.cpu_stall); end
    @(negedge clk);
    rst = 1'b0;
    drive_cpu(1'b0, 1'b0, 24'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 24'h000010, 32'h0);
    drive_dma(1'b1, 1'b0, 24'h000020, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_cmp++; if (bus.dma_gnt !== 1'b0) begin n_err++; $display("FAIL wc_build k=%0d got=%0b exp=0", k, bus.dma_gnt); end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b0 || bus.ram_cs !== 1'b0) begin n_err++; $display("FAIL wc_rst got=g%0b cs%0b exp=00", bus.dma_gnt, bus.ram_cs); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_cmp++; if (bus.dma_gnt !== (k == 5) || bus.cpu_stall !== (k == 5)) begin n_err++; $display("FAIL wc_clear k=%0d got=g%0b st%0b exp=%0b", k, bus.dma_gnt, bus.cpu_stall, (k == 5)); end
      @(negedge clk);
    end
    drive_cpu(1'b0, 1'b0, 24'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 24'h0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_q = 32'h0;
    test_reset();
    test_cpu_rw();
    test_dma_only();
    test_forced_slot();
    test_stdout();
    test_dma_io();
    test_halt();
    test_reset_midstream();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
